// File: rtl/reservation_station_pkg.sv
// Shared types and helpers for the integer/branch reservation station.
package reservation_station_pkg;

   localparam int RS_SIZE_BIT  = 3;
   localparam int RS_SIZE      = 1 << RS_SIZE_BIT;
   localparam int ROB_SIZE_BIT = 5;

   typedef enum logic [3:0] {
      RS_OP_ADD  = 4'd0,
      RS_OP_SUB  = 4'd1,
      RS_OP_AND  = 4'd2,
      RS_OP_OR   = 4'd3,
      RS_OP_XOR  = 4'd4,
      RS_OP_SLL  = 4'd5,
      RS_OP_SRL  = 4'd6,
      RS_OP_SRA  = 4'd7,
      RS_OP_SLT  = 4'd8,
      RS_OP_SLTU = 4'd9,
      RS_OP_BEQ  = 4'd10,
      RS_OP_BNE  = 4'd11,
      RS_OP_BLT  = 4'd12,
      RS_OP_BGE  = 4'd13,
      RS_OP_BLTU = 4'd14,
      RS_OP_BGEU = 4'd15
   } rs_op_e;

   typedef struct packed {
      logic                    busy;
      logic [3:0]              op;
      logic [ROB_SIZE_BIT-1:0] rob_id;
      logic                    qj_busy;
      logic [ROB_SIZE_BIT-1:0] qj;
      logic [31:0]             vj;
      logic                    qk_busy;
      logic [ROB_SIZE_BIT-1:0] qk;
      logic [31:0]             vk;
      logic [31:0]             pc;
      logic [31:0]             imm;
   } rs_entry_t;

   function automatic logic tag_hit(input logic                    pend,
                                    input logic [ROB_SIZE_BIT-1:0] tag,
                                    input logic                    bus_set,
                                    input logic [ROB_SIZE_BIT-1:0] bus_id);
      return pend && bus_set && (tag == bus_id);
   endfunction

   // Scans downward so the lowest set bit is the one left standing.
   function automatic logic [RS_SIZE_BIT-1:0] lowest_idx(input logic [RS_SIZE-1:0] vec);
      logic [RS_SIZE_BIT-1:0] idx;
      idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = RS_SIZE_BIT'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/reservation_station_alu.sv
// Combinational integer ALU and branch resolver for the reservation station.
module alu_unit
   import reservation_station_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] vj_i,
   input  logic [31:0] vk_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] imm_i,
   output logic [31:0] result_o
);

   logic [31:0] taken_tgt_s;
   logic [31:0] fall_tgt_s;
   logic [31:0] br_tgt_s;
   logic        is_br_s;
   logic        taken_s;

   assign taken_tgt_s = pc_i + imm_i;
   assign fall_tgt_s  = pc_i + 32'd4;
   assign br_tgt_s    = taken_s ? taken_tgt_s : fall_tgt_s;

   // Operation decode; branches report the next pc with the taken flag in bit 0.
   always_comb begin
      result_o = 32'd0;
      is_br_s  = 1'b0;
      taken_s  = 1'b0;
      case (rs_op_e'(op_i))
         RS_OP_ADD:  result_o = vj_i + vk_i;
         RS_OP_SUB:  result_o = vj_i - vk_i;
         RS_OP_AND:  result_o = vj_i & vk_i;
         RS_OP_OR:   result_o = vj_i | vk_i;
         RS_OP_XOR:  result_o = vj_i ^ vk_i;
         RS_OP_SLL:  result_o = vj_i << vk_i[4:0];
         RS_OP_SRL:  result_o = vj_i >> vk_i[4:0];
         RS_OP_SRA:  result_o = $signed(vj_i) >>> vk_i[4:0];
         RS_OP_SLT:  result_o = {31'd0, $signed(vj_i) < $signed(vk_i)};
         RS_OP_SLTU: result_o = {31'd0, vj_i < vk_i};
         RS_OP_BEQ:  begin is_br_s = 1'b1; taken_s = (vj_i == vk_i); end
         RS_OP_BNE:  begin is_br_s = 1'b1; taken_s = (vj_i != vk_i); end
         RS_OP_BLT:  begin is_br_s = 1'b1; taken_s = ($signed(vj_i) <  $signed(vk_i)); end
         RS_OP_BGE:  begin is_br_s = 1'b1; taken_s = ($signed(vj_i) >= $signed(vk_i)); end
         RS_OP_BLTU: begin is_br_s = 1'b1; taken_s = (vj_i <  vk_i); end
         RS_OP_BGEU: begin is_br_s = 1'b1; taken_s = (vj_i >= vk_i); end
         default:    result_o = 32'd0;
      endcase
      if (is_br_s) begin
         result_o = {br_tgt_s[31:1], taken_s};
      end else begin
         result_o = result_o;
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Eight-entry out-of-order issue buffer: snoops both result buses, picks the
// lowest ready entry each cycle and registers its ALU/branch result.
module reservation_station
   import reservation_station_pkg::*;
(
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    clear_flag,
   input  logic                    issue_valid,
   input  logic [3:0]              issue_op,
   input  logic [ROB_SIZE_BIT-1:0] issue_rob_id,
   input  logic [31:0]             issue_vj,
   input  logic [31:0]             issue_vk,
   input  logic                    issue_qj_busy,
   input  logic                    issue_qk_busy,
   input  logic [ROB_SIZE_BIT-1:0] issue_qj,
   input  logic [ROB_SIZE_BIT-1:0] issue_qk,
   input  logic [31:0]             issue_pc,
   input  logic [31:0]             issue_imm,
   input  logic                    lsb_is_set,
   input  logic [ROB_SIZE_BIT-1:0] lsb_set_id,
   input  logic [31:0]             lsb_set_val,
   output logic                    rs_full,
   output logic                    rs_is_set,
   output logic [ROB_SIZE_BIT-1:0] rs_set_id,
   output logic [31:0]             rs_set_val
);

   rs_entry_t               entry_q [RS_SIZE];
   rs_entry_t               entry_d [RS_SIZE];
   rs_entry_t               new_entry_s;
   logic                    is_set_q, is_set_d;
   logic [ROB_SIZE_BIT-1:0] set_id_q, set_id_d;
   logic [31:0]             set_val_q, set_val_d;

   logic [RS_SIZE-1:0]      free_vec_s;
   logic [RS_SIZE-1:0]      ready_vec_s;
   logic [RS_SIZE_BIT-1:0]  free_idx_s;
   logic [RS_SIZE_BIT-1:0]  sel_idx_s;
   logic                    free_found_s;
   logic                    sel_found_s;
   logic [31:0]             alu_res_s;

   // Free and ready vectors come from registered state only.
   always_comb begin
      free_vec_s  = '0;
      ready_vec_s = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         free_vec_s[i]  = ~entry_q[i].busy;
         ready_vec_s[i] = entry_q[i].busy & ~entry_q[i].qj_busy & ~entry_q[i].qk_busy;
      end
   end

   assign free_found_s = |free_vec_s;
   assign sel_found_s  = |ready_vec_s;
   assign free_idx_s   = lowest_idx(free_vec_s);
   assign sel_idx_s    = lowest_idx(ready_vec_s);
   assign rs_full      = (free_vec_s == '0) || (issue_valid && $onehot(free_vec_s));

   alu_unit u_alu (
      .op_i     (entry_q[sel_idx_s].op),
      .vj_i     (entry_q[sel_idx_s].vj),
      .vk_i     (entry_q[sel_idx_s].vk),
      .pc_i     (entry_q[sel_idx_s].pc),
      .imm_i    (entry_q[sel_idx_s].imm),
      .result_o (alu_res_s)
   );

   // Incoming instruction, with operands captured from a same-cycle broadcast.
   always_comb begin
      new_entry_s        = '0;
      new_entry_s.busy   = 1'b1;
      new_entry_s.op     = issue_op;
      new_entry_s.rob_id = issue_rob_id;
      new_entry_s.pc     = issue_pc;
      new_entry_s.imm    = issue_imm;
      new_entry_s.qj     = issue_qj;
      new_entry_s.qk     = issue_qk;
      if (tag_hit(issue_qj_busy, issue_qj, is_set_q, set_id_q)) begin
         new_entry_s.qj_busy = 1'b0;
         new_entry_s.vj      = set_val_q;
      end else if (tag_hit(issue_qj_busy, issue_qj, lsb_is_set, lsb_set_id)) begin
         new_entry_s.qj_busy = 1'b0;
         new_entry_s.vj      = lsb_set_val;
      end else begin
         new_entry_s.qj_busy = issue_qj_busy;
         new_entry_s.vj      = issue_vj;
      end
      if (tag_hit(issue_qk_busy, issue_qk, is_set_q, set_id_q)) begin
         new_entry_s.qk_busy = 1'b0;
         new_entry_s.vk      = set_val_q;
      end else if (tag_hit(issue_qk_busy, issue_qk, lsb_is_set, lsb_set_id)) begin
         new_entry_s.qk_busy = 1'b0;
         new_entry_s.vk      = lsb_set_val;
      end else begin
         new_entry_s.qk_busy = issue_qk_busy;
         new_entry_s.vk      = issue_vk;
      end
   end

   // Next state: flush, else wakeup, free the selected entry, accept the issue.
   always_comb begin
      entry_d   = entry_q;
      is_set_d  = is_set_q;
      set_id_d  = set_id_q;
      set_val_d = set_val_q;
      if (rst_in || (clear_flag && rdy_in)) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i] = '0;
         end
         is_set_d  = 1'b0;
         set_id_d  = '0;
         set_val_d = 32'd0;
      end else if (rdy_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (tag_hit(entry_q[i].qj_busy, entry_q[i].qj, is_set_q, set_id_q)) begin
               entry_d[i].qj_busy = 1'b0;
               entry_d[i].vj      = set_val_q;
            end else if (tag_hit(entry_q[i].qj_busy, entry_q[i].qj, lsb_is_set, lsb_set_id)) begin
               entry_d[i].qj_busy = 1'b0;
               entry_d[i].vj      = lsb_set_val;
            end else begin
               entry_d[i].qj_busy = entry_q[i].qj_busy;
            end
            if (tag_hit(entry_q[i].qk_busy, entry_q[i].qk, is_set_q, set_id_q)) begin
               entry_d[i].qk_busy = 1'b0;
               entry_d[i].vk      = set_val_q;
            end else if (tag_hit(entry_q[i].qk_busy, entry_q[i].qk, lsb_is_set, lsb_set_id)) begin
               entry_d[i].qk_busy = 1'b0;
               entry_d[i].vk      = lsb_set_val;
            end else begin
               entry_d[i].qk_busy = entry_q[i].qk_busy;
            end
         end
         if (sel_found_s) begin
            entry_d[sel_idx_s].busy = 1'b0;
            set_id_d                = entry_q[sel_idx_s].rob_id;
            set_val_d               = alu_res_s;
         end else begin
            set_id_d  = set_id_q;
            set_val_d = set_val_q;
         end
         is_set_d = sel_found_s;
         if (issue_valid && free_found_s) begin
            entry_d[free_idx_s] = new_entry_s;
         end else begin
            entry_d[free_idx_s] = entry_d[free_idx_s];
         end
      end else begin
         is_set_d = is_set_q;
      end
   end

   // State registers; reset and flush are folded into the next-state logic.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
         entry_q[i] <= entry_d[i];
      end
      is_set_q  <= is_set_d;
      set_id_q  <= set_id_d;
      set_val_q <= set_val_d;
   end

   assign rs_is_set  = is_set_q;
   assign rs_set_id  = set_id_q;
   assign rs_set_val = set_val_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench: ALU/branch vector table plus wakeup, full, flush and stall sequences.
module tb_reservation_station;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_flag, issue_valid;
   logic [3:0]  issue_op;
   logic [4:0]  issue_rob_id, issue_qj, issue_qk, lsb_set_id;
   logic [31:0] issue_vj, issue_vk, issue_pc, issue_imm, lsb_set_val;
   logic        issue_qj_busy, issue_qk_busy, lsb_is_set;
   logic        rs_full, rs_is_set;
   logic [4:0]  rs_set_id;
   logic [31:0] rs_set_val;

   int total = 0;
   int bad   = 0;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                          SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9,
                          BEQ = 4'd10, BNE = 4'd11, BLT = 4'd12, BGE = 4'd13,
                          BLTU = 4'd14, BGEU = 4'd15;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] vj, vk, pc, imm, exp;
   } vec_t;
   vec_t vecs[17];

   reservation_station dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
      .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj_busy(issue_qj_busy),
      .issue_qk_busy(issue_qk_busy), .issue_qj(issue_qj), .issue_qk(issue_qk),
      .issue_pc(issue_pc), .issue_imm(issue_imm), .lsb_is_set(lsb_is_set),
      .lsb_set_id(lsb_set_id), .lsb_set_val(lsb_set_val), .rs_full(rs_full),
      .rs_is_set(rs_is_set), .rs_set_id(rs_set_id), .rs_set_val(rs_set_val)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] tag,
                        input logic [31:0] vj, input logic [31:0] vk,
                        input logic qjb, input logic [4:0] qj);
      issue_valid   = 1'b1;
      issue_op      = op;
      issue_rob_id  = tag;
      issue_vj      = vj;
      issue_vk      = vk;
      issue_qj_busy = qjb;
      issue_qj      = qj;
      issue_qk_busy = 1'b0;
      issue_qk      = 5'd0;
      issue_pc      = 32'd0;
      issue_imm     = 32'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{ADD,  32'd5,          32'd7,          32'd0,     32'd0,     32'd12};
      vecs[1]  = '{SUB,  32'd3,          32'd5,          32'd0,     32'd0,     32'hFFFF_FFFE};
      vecs[2]  = '{AND_, 32'h0000_F0F0,  32'h0000_FF00,  32'd0,     32'd0,     32'h0000_F000};
      vecs[3]  = '{OR_,  32'h0000_F0F0,  32'h0000_0F0F,  32'd0,     32'd0,     32'h0000_FFFF};
      vecs[4]  = '{XOR_, 32'h0000_00FF,  32'h0000_000F,  32'd0,     32'd0,     32'h0000_00F0};
      vecs[5]  = '{SLL,  32'd1,          32'h0000_0021,  32'd0,     32'd0,     32'd2};
      vecs[6]  = '{SRL,  32'h8000_0000,  32'd4,          32'd0,     32'd0,     32'h0800_0000};
      vecs[7]  = '{SRA,  32'h8000_0000,  32'd4,          32'd0,     32'd0,     32'hF800_0000};
      vecs[8]  = '{SLT,  32'hFFFF_FFFF,  32'd1,          32'd0,     32'd0,     32'd1};
      vecs[9]  = '{SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,     32'd0,     32'd0};
      vecs[10] = '{BEQ,  32'd1,          32'd1,          32'h100,   32'h20,    32'h121};
      vecs[11] = '{BNE,  32'd1,          32'd1,          32'h100,   32'h20,    32'h104};
      vecs[12] = '{BLT,  32'hFFFF_FFFF,  32'd1,          32'h200,   32'h10,    32'h211};
      vecs[13] = '{BGE,  32'hFFFF_FFFF,  32'd1,          32'h200,   32'h10,    32'h204};
      vecs[14] = '{BLTU, 32'hFFFF_FFFF,  32'd1,          32'h200,   32'h10,    32'h204};
      vecs[15] = '{BGEU, 32'hFFFF_FFFF,  32'd1,          32'h200,   32'h10,    32'h211};
      vecs[16] = '{ADD,  32'hFFFF_FFFF,  32'd2,          32'd0,     32'd0,     32'd1};

      rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0;
      lsb_is_set = 1'b0; lsb_set_id = 5'd0; lsb_set_val = 32'd0;
      drive(ADD, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      issue_valid = 1'b0;
      tick(); tick();
      rst_in = 1'b0;
      check("reset_is_set", {31'd0, rs_is_set}, 32'd0);
      check("reset_id", {27'd0, rs_set_id}, 32'd0);
      check("reset_val", rs_set_val, 32'd0);
      check("reset_full", {31'd0, rs_full}, 32'd0);

      // Table: ready operands, result appears two cycles after issue.
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].op, 5'(i + 3), vecs[i].vj, vecs[i].vk, 1'b0, 5'd0);
         issue_pc  = vecs[i].pc;
         issue_imm = vecs[i].imm;
         tick();
         issue_valid = 1'b0;
         tick();
         check($sformatf("vec%0d_set", i), {31'd0, rs_is_set}, 32'd1);
         check($sformatf("vec%0d_id", i), {27'd0, rs_set_id}, 32'(i + 3));
         check($sformatf("vec%0d_val", i), rs_set_val, vecs[i].exp);
      end
      tick();
      check("idle_set", {31'd0, rs_is_set}, 32'd0);

      // LSB wakeup one cycle after issue.
      drive(SUB, 5'd20, 32'd0, 32'd1, 1'b1, 5'd9);
      tick();
      issue_valid = 1'b0;
      lsb_is_set = 1'b1; lsb_set_id = 5'd9; lsb_set_val = 32'd10;
      tick();
      lsb_is_set = 1'b0;
      check("wake_not_yet", {31'd0, rs_is_set}, 32'd0);
      tick();
      check("wake_set", {31'd0, rs_is_set}, 32'd1);
      check("wake_id", {27'd0, rs_set_id}, 32'd20);
      check("wake_val", rs_set_val, 32'd9);

      // Same-cycle capture from own result bus.
      drive(ADD, 5'd4, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0);
      tick();
      issue_valid = 1'b0;
      tick();
      check("bypass_src_id", {27'd0, rs_set_id}, 32'd4);
      drive(SRA, 5'd7, 32'd0, 32'd4, 1'b1, 5'd4);
      tick();
      issue_valid = 1'b0;
      tick();
      check("bypass_set", {31'd0, rs_is_set}, 32'd1);
      check("bypass_id", {27'd0, rs_set_id}, 32'd7);
      check("bypass_val", rs_set_val, 32'hFFFF_FFFF);
      tick();

      // Fill all eight entries with distinct pending producers.
      for (int k = 0; k < 8; k++) begin
         drive(ADD, 5'(20 + k), 32'd0, 32'(k), 1'b1, 5'(16 + k));
         #1;
         check($sformatf("fill%0d_full", k), {31'd0, rs_full}, (k == 7) ? 32'd1 : 32'd0);
         tick();
      end
      issue_valid = 1'b0;
      #1;
      check("full_at_zero_free", {31'd0, rs_full}, 32'd1);
      lsb_is_set = 1'b1; lsb_set_id = 5'd16; lsb_set_val = 32'd100;
      tick();
      lsb_is_set = 1'b0;
      check("full_after_wake", {31'd0, rs_full}, 32'd1);
      check("full_no_result_yet", {31'd0, rs_is_set}, 32'd0);
      tick();
      check("full_released", {31'd0, rs_full}, 32'd0);
      check("drain_set", {31'd0, rs_is_set}, 32'd1);
      check("drain_id", {27'd0, rs_set_id}, 32'd20);
      check("drain_val", rs_set_val, 32'd100);

      // Flush while busy and broadcasting; same-cycle issue is dropped.
      clear_flag = 1'b1;
      drive(ADD, 5'd9, 32'd1, 32'd1, 1'b0, 5'd0);
      tick();
      clear_flag = 1'b0; issue_valid = 1'b0;
      check("flush_set", {31'd0, rs_is_set}, 32'd0);
      check("flush_id", {27'd0, rs_set_id}, 32'd0);
      check("flush_val", rs_set_val, 32'd0);
      check("flush_full", {31'd0, rs_full}, 32'd0);
      lsb_is_set = 1'b1; lsb_set_id = 5'd17; lsb_set_val = 32'd5;
      tick();
      lsb_is_set = 1'b0;
      tick(); tick();
      check("flush_empty", {31'd0, rs_is_set}, 32'd0);

      // Stall freezes outputs; issue overlaps select.
      drive(ADD, 5'd11, 32'd2, 32'd3, 1'b0, 5'd0);
      tick();
      drive(ADD, 5'd12, 32'd4, 32'd4, 1'b0, 5'd0);
      tick();
      issue_valid = 1'b0;
      rdy_in = 1'b0;
      check("pre_stall_id", {27'd0, rs_set_id}, 32'd11);
      tick(); tick();
      check("stall_set", {31'd0, rs_is_set}, 32'd1);
      check("stall_id", {27'd0, rs_set_id}, 32'd11);
      check("stall_val", rs_set_val, 32'd5);
      rdy_in = 1'b1;
      tick();
      check("resume_id", {27'd0, rs_set_id}, 32'd12);
      check("resume_val", rs_set_val, 32'd8);
      tick();
      check("resume_idle", {31'd0, rs_is_set}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
